// File: rtl/asyn_fifo_rd_stream.sv
// asyn_fifo_rd_stream
// Read-side consumer of the async FIFO. It pops words from the show-ahead
// FIFO read port, holds them in a 2-entry output queue, and presents them to
// downstream logic as a valid/ready stream. Every BURST_LEN-th delivered word
// is tagged with m_last.
//
// Ports:
//   rclk      read-domain clock, all state on its rising edge
//   rrst_n    asynchronous active-low reset
//   rempty    FIFO empty flag (rclk domain)
//   rdata     FIFO show-ahead read data, valid while rempty=0
//   rinc      FIFO pop strobe
//   enable    permits new pops; buffered words drain regardless
//   m_data    stream data (queue head)
//   m_valid   stream valid
//   m_last    final word of the current burst
//   m_ready   downstream accept
//   occ       output-queue occupancy (0..2)
//   beat_cnt  saturating count of words accepted downstream
module asyn_fifo_rd_stream #(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             enable,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam int POS_W = $clog2(BURST_LEN);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(BURST_LEN - 1);

    logic [DSIZE-1:0] slot0;
    logic [DSIZE-1:0] slot1;
    logic [POS_W-1:0] pos;
    logic             xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // occ never exceeds 2, so occ[1] alone means "queue full". Gating with
    // rrst_n keeps the FIFO untouched while reset is held.
    assign rinc    = rrst_n & enable & ~rempty & ~occ[1];
    assign m_valid = (occ != 2'd0);
    assign m_data  = slot0;
    assign m_last  = m_valid & (pos == LAST_POS);
    assign xfer    = m_valid & m_ready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ      <= 2'd0;
            slot0    <= '0;
            slot1    <= '0;
            pos      <= '0;
            beat_cnt <= '0;
        end else begin
            case ({rinc, xfer})
                2'b10: begin
                    if (occ == 2'd0) slot0 <= rdata;
                    else             slot1 <= rdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                // Push and pop together only happen at occ=1 (rinc is off at
                // occ=2 and there is nothing to pop at occ=0): head is replaced.
                2'b11: slot0 <= rdata;
                default: ;
            endcase
            if (xfer) begin
                pos      <= (pos == LAST_POS) ? '0 : pos + POS_W'(1);
                beat_cnt <= sat_inc(beat_cnt);
            end
        end
    end

endmodule

// File: tb/tb_asyn_fifo_rd_stream.sv
// Testbench for asyn_fifo_rd_stream: a small show-ahead FIFO model feeds the
// design; a table of per-cycle vectors covers steady streaming, and
// hand-written sequences cover backpressure, reset, enable and empty corners.
// A second instance built with CNT_W=4 shares all inputs for saturation.
module tb_asyn_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       enable;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic [1:0] occ;
    logic [15:0] beat_cnt;

    logic       rinc4;
    logic [7:0] m_data4;
    logic       m_valid4;
    logic       m_last4;
    logic [1:0] occ4;
    logic [3:0] beat_cnt4;

    // FIFO model: preloaded by the stimulus, popped on rinc.
    logic [7:0] mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       hold_empty = 1'b0;

    assign rempty = (rd_ptr == wr_ptr) || hold_empty;
    assign rdata  = mem[rd_ptr[7:0]];

    always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 1;

    always #5 rclk = ~rclk;

    asyn_fifo_rd_stream #(.DSIZE(8), .BURST_LEN(4), .CNT_W(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .enable(enable), .m_data(m_data), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready), .occ(occ), .beat_cnt(beat_cnt)
    );

    asyn_fifo_rd_stream #(.DSIZE(8), .BURST_LEN(4), .CNT_W(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
        .rinc(rinc4), .enable(enable), .m_data(m_data4), .m_valid(m_valid4),
        .m_last(m_last4), .m_ready(m_ready), .occ(occ4), .beat_cnt(beat_cnt4)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int tb_pos = 0;
    int tb_beat = 0;
    int rp;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        x_rinc;
        logic        x_valid;
        logic [7:0]  x_data;
        logic        x_last;
        logic [1:0]  x_occ;
        logic [15:0] x_beat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = 8'(first + i);
            wr_ptr++;
        end
    endtask

    // Accept n words with m_ready=1, checking order and burst tagging.
    task automatic drain(input logic [7:0] first, input int n);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        m_ready = 1'b1;
        while (got < n && cyc < 60) begin
            #1;
            if (m_valid) begin
                chk("drain_data", {24'd0, m_data}, {24'd0, 8'(first + got)});
                chk("drain_last", {31'd0, m_last}, {31'd0, (tb_pos == 3)});
                chk("drain_data_w4", {24'd0, m_data4}, {24'd0, 8'(first + got)});
                tb_pos  = (tb_pos + 1) % 4;
                tb_beat = tb_beat + 1;
                got++;
            end
            if (got < n) @(negedge rclk);
            cyc++;
        end
        if (got < n) chk("drain_timeout", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            en   rdy  rinc valid data   last occ    beat
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 2'd1, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 2'd1, 16'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 2'd1, 16'd2};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 2'd1, 16'd3};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 2'd1, 16'd4};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 2'd1, 16'd5};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 2'd1, 16'd6};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 2'd1, 16'd7};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd8};

        // Reset with a non-empty FIFO and enable high
        rrst_n  = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        preload(8'h10, 8);
        #1 rrst_n = 1'b0;
        repeat (2) @(negedge rclk);
        #1;
        chk("rst_rinc", {31'd0, rinc}, 32'd0);
        chk("rst_occ", {30'd0, occ}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_beat", {16'd0, beat_cnt}, 32'd0);
        @(negedge rclk);
        enable = 1'b0;
        rrst_n = 1'b1;

        // Steady streaming of 0x10..0x17
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            enable  = vecs[i].en;
            m_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_rinc", i), {31'd0, rinc}, {31'd0, vecs[i].x_rinc});
            chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].x_valid});
            if (vecs[i].x_valid)
                chk($sformatf("vec%0d_data", i), {24'd0, m_data}, {24'd0, vecs[i].x_data});
            chk($sformatf("vec%0d_last", i), {31'd0, m_last}, {31'd0, vecs[i].x_last});
            chk($sformatf("vec%0d_occ", i), {30'd0, occ}, {30'd0, vecs[i].x_occ});
            chk($sformatf("vec%0d_beat", i), {16'd0, beat_cnt}, {16'd0, vecs[i].x_beat});
        end
        tb_pos  = 0;
        tb_beat = 8;

        // Backpressure: m_ready low for 5 cycles, exactly 2 pops
        @(negedge rclk);
        preload(8'h10, 8);
        rp = rd_ptr;
        enable  = 1'b1;
        m_ready = 1'b0;
        #1;
        chk("bp_c0_rinc", {31'd0, rinc}, 32'd1);
        for (int c = 1; c < 5; c++) begin
            @(negedge rclk);
            #1;
            chk("bp_hold_data", {24'd0, m_data}, 32'h10);
            chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
        end
        chk("bp_occ", {30'd0, occ}, 32'd2);
        chk("bp_rinc", {31'd0, rinc}, 32'd0);
        chk("bp_pops", rd_ptr - rp, 32'd2);
        drain(8'h10, 8);
        @(negedge rclk);
        #1;
        chk("bp_beat", {16'd0, beat_cnt}, tb_beat);

        // Reset mid-stream with occ=2 and pos=2
        @(negedge rclk);
        preload(8'h30, 4);
        m_ready = 1'b1;
        #1;
        chk("mr_c0_rinc", {31'd0, rinc}, 32'd1);
        @(negedge rclk);
        #1;
        chk("mr_c1_data", {24'd0, m_data}, 32'h30);
        @(negedge rclk);
        #1;
        chk("mr_c2_data", {24'd0, m_data}, 32'h31);
        @(negedge rclk);
        m_ready = 1'b0;
        #1;
        chk("mr_c3_data", {24'd0, m_data}, 32'h32);
        @(negedge rclk);
        #1;
        chk("mr_occ2", {30'd0, occ}, 32'd2);
        chk("mr_last_pos2", {31'd0, m_last}, 32'd0);
        preload(8'h40, 1);
        #2 rrst_n = 1'b0;
        #1;
        chk("mr_occ", {30'd0, occ}, 32'd0);
        chk("mr_valid", {31'd0, m_valid}, 32'd0);
        chk("mr_beat", {16'd0, beat_cnt}, 32'd0);
        chk("mr_rinc", {31'd0, rinc}, 32'd0);
        @(negedge rclk);
        #1;
        chk("mr_rinc_held", {31'd0, rinc}, 32'd0);
        chk("mr_occ_held", {30'd0, occ}, 32'd0);
        @(negedge rclk);
        rrst_n  = 1'b1;
        tb_pos  = 0;
        tb_beat = 0;
        drain(8'h40, 1);

        // Empty FIFO with enable high
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            #1;
            chk("empty_rinc", {31'd0, rinc}, 32'd0);
            chk("empty_valid", {31'd0, m_valid}, 32'd0);
        end

        // Enable dropped with occ=2 and FIFO non-empty
        @(negedge rclk);
        preload(8'h50, 8);
        enable  = 1'b1;
        m_ready = 1'b0;
        #1;
        chk("en_c0_rinc", {31'd0, rinc}, 32'd1);
        @(negedge rclk);
        #1;
        chk("en_c1_occ", {30'd0, occ}, 32'd1);
        @(negedge rclk);
        #1;
        chk("en_c2_occ", {30'd0, occ}, 32'd2);
        enable = 1'b0;
        #1;
        chk("en_off_rinc", {31'd0, rinc}, 32'd0);
        drain(8'h50, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            #1;
            chk("en_off_valid", {31'd0, m_valid}, 32'd0);
            chk("en_off_rinc2", {31'd0, rinc}, 32'd0);
        end
        enable = 1'b1;
        drain(8'h52, 6);

        // rempty rising while a pop is pending
        @(negedge rclk);
        preload(8'h60, 1);
        hold_empty = 1'b1;
        rp = rd_ptr;
        #1;
        chk("he_rinc", {31'd0, rinc}, 32'd0);
        @(negedge rclk);
        #1;
        chk("he_pops", rd_ptr - rp, 32'd0);
        chk("he_valid", {31'd0, m_valid}, 32'd0);
        hold_empty = 1'b0;
        drain(8'h60, 1);
        @(negedge rclk);
        #1;
        chk("he_beat", {16'd0, beat_cnt}, tb_beat);

        // Saturation of the narrow counter
        rrst_n = 1'b0;
        enable = 1'b0;
        @(negedge rclk);
        rrst_n  = 1'b1;
        tb_pos  = 0;
        tb_beat = 0;
        preload(8'h70, 20);
        enable = 1'b1;
        drain(8'h70, 20);
        @(negedge rclk);
        #1;
        chk("sat_beat16", {16'd0, beat_cnt}, 32'd20);
        chk("sat_beat4", {28'd0, beat_cnt4}, 32'd15);
        repeat (2) @(negedge rclk);
        #1;
        chk("sat_beat4_hold", {28'd0, beat_cnt4}, 32'd15);
        chk("sat_w4_idle", {28'd0, occ4, m_valid4, m_last4}, {28'd0, 2'd0, rinc4, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
